// File: rtl/he_pkg.sv
// Shared types and width helpers for the histogram-equalisation engine.
package he_pkg;

  typedef enum logic [2:0] {StIdle, StClear, StHist, StCdf, StMap} state_e;

  typedef enum logic {PhScan, PhWait} cdf_ph_e;

  function automatic int unsigned calc_l(input int unsigned pix_w);
    return 32'd1 << pix_w;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned num_pixels);
    return $clog2(num_pixels + 1);
  endfunction

endpackage

// File: rtl/he_div.sv
// Restoring unsigned divider, one quotient bit per cycle.
// start_i latches operands; done_o pulses once when quot_o/rem_o are final.
module he_div #(
  parameter int unsigned NUM_W = 16,
  parameter int unsigned DEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] quot_o,
  output logic [DEN_W-1:0] rem_o
);
  localparam int unsigned CntW = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] quot_q, quot_d;
  logic [DEN_W-1:0] rem_q, rem_d, den_q, den_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [DEN_W:0]   trial;

  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    trial  = {rem_q, quot_q[NUM_W-1]};
    if (busy_q) begin
      if (trial >= {1'b0, den_q}) begin
        rem_d  = DEN_W'(trial - {1'b0, den_q});
        quot_d = {quot_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d  = trial[DEN_W-1:0];
        quot_d = {quot_q[NUM_W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start_i) begin
      quot_d = num_i;
      rem_d  = '0;
      den_d  = den_i;
      cnt_d  = CntW'(NUM_W);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quot_q <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/he_engine.sv
// Histogram-equalisation engine: histogram a frame, build a CDF-normalised LUT,
// then remap the pixel stream through it with valid/ready backpressure.
module he_engine #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned NUM_PIXELS = 290400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] pix_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             busy
);
  import he_pkg::*;

  localparam int unsigned L     = calc_l(PIX_W);
  localparam int unsigned CNT_W = calc_cnt_w(NUM_PIXELS);
  localparam int unsigned NumW  = CNT_W + PIX_W;

  localparam logic [CNT_W-1:0] NumPix  = CNT_W'(NUM_PIXELS);
  localparam logic [CNT_W-1:0] LastPix = CNT_W'(NUM_PIXELS - 1);
  localparam logic [PIX_W-1:0] LastIdx = PIX_W'(L - 1);
  localparam logic [NumW-1:0]  Lm1     = NumW'(L - 1);

  logic [CNT_W-1:0] bin_ram [L];
  logic [PIX_W-1:0] lut_ram [L];

  state_e           state_q, state_d;
  cdf_ph_e          ph_q, ph_d;
  logic [PIX_W-1:0] idx_q, idx_d, hist_addr_q, hist_addr_d, pix_out_q, pix_out_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, cdf_q, cdf_d, cdf_min_q, cdf_min_d;
  logic [CNT_W-1:0] hist_rd_q, hist_rd_d;
  logic             min_vld_q, min_vld_d, single_q, single_d;
  logic             hist_vld_q, hist_vld_d, out_valid_q, out_valid_d;

  logic             bin_we, lut_we, div_start, div_busy, div_done, first_nz;
  logic [PIX_W-1:0] bin_wa, lut_wa, lut_wd;
  logic [CNT_W-1:0] bin_wd, hist_wr_val, cdf_new, cmin, den_val, div_rem;
  logic [NumW-1:0]  num_val, div_quot;

  assign hist_wr_val = hist_rd_q + CNT_W'(1);
  assign cdf_new     = cdf_q + bin_ram[idx_q];
  assign first_nz    = !min_vld_q && (cdf_new != '0);
  assign cmin        = first_nz ? cdf_new : cdf_min_q;
  assign den_val     = NumPix - cmin;
  assign num_val     = NumW'(cdf_new - cmin) * Lm1 + NumW'(den_val >> 1);

  always_comb begin
    state_d     = state_q;
    ph_d        = ph_q;
    idx_d       = idx_q;
    pix_cnt_d   = pix_cnt_q;
    cdf_d       = cdf_q;
    cdf_min_d   = cdf_min_q;
    min_vld_d   = min_vld_q;
    single_d    = single_q;
    hist_vld_d  = 1'b0;
    hist_addr_d = hist_addr_q;
    hist_rd_d   = hist_rd_q;
    pix_out_d   = pix_out_q;
    out_valid_d = out_valid_q;
    bin_we      = 1'b0;
    bin_wa      = hist_addr_q;
    bin_wd      = hist_wr_val;
    lut_we      = 1'b0;
    lut_wa      = idx_q;
    lut_wd      = idx_q;
    div_start   = 1'b0;
    pix_ready   = 1'b0;

    // Second stage of the histogram read-modify-write.
    if (hist_vld_q) begin
      bin_we = 1'b1;
      if (hist_wr_val == NumPix) single_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      StClear: begin
        bin_we    = 1'b1;
        bin_wa    = idx_q;
        bin_wd    = '0;
        idx_d     = idx_q + PIX_W'(1);
        pix_cnt_d = '0;
        cdf_d     = '0;
        min_vld_d = 1'b0;
        single_d  = 1'b0;
        ph_d      = PhScan;
        if (idx_q == LastIdx) state_d = StHist;
      end
      StHist: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          hist_vld_d  = 1'b1;
          hist_addr_d = pix_in;
          // Forward the in-flight increment when the same bin repeats back-to-back.
          hist_rd_d   = (hist_vld_q && hist_addr_q == pix_in) ? hist_wr_val : bin_ram[pix_in];
          pix_cnt_d   = pix_cnt_q + CNT_W'(1);
          if (pix_cnt_q == LastPix) state_d = StCdf;
        end
      end
      StCdf: begin
        if (ph_q == PhScan) begin
          // Hold off until the last histogram write has landed.
          if (!hist_vld_q) begin
            cdf_d = cdf_new;
            if (first_nz) begin
              min_vld_d = 1'b1;
              cdf_min_d = cdf_new;
            end
            if (single_q || cdf_new == '0) begin
              lut_we = 1'b1;
              lut_wd = single_q ? idx_q : '0;
              idx_d  = idx_q + PIX_W'(1);
              if (idx_q == LastIdx) state_d = StMap;
            end else begin
              div_start = 1'b1;
              ph_d      = PhWait;
            end
          end
        end else if (div_done) begin
          lut_we = 1'b1;
          lut_wd = div_quot[PIX_W-1:0];
          ph_d   = PhScan;
          idx_d  = idx_q + PIX_W'(1);
          if (idx_q == LastIdx) state_d = StMap;
        end
      end
      StMap: begin
        if (start) begin
          state_d     = StClear;
          idx_d       = '0;
          out_valid_d = 1'b0;
        end else begin
          pix_ready = !out_valid_q || out_ready;
          if (pix_valid && pix_ready) begin
            pix_out_d   = lut_ram[pix_in];
            out_valid_d = 1'b1;
          end else if (out_ready) begin
            out_valid_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ph_q        <= PhScan;
      idx_q       <= '0;
      pix_cnt_q   <= '0;
      cdf_q       <= '0;
      cdf_min_q   <= '0;
      min_vld_q   <= 1'b0;
      single_q    <= 1'b0;
      hist_vld_q  <= 1'b0;
      hist_addr_q <= '0;
      hist_rd_q   <= '0;
      pix_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      idx_q       <= idx_d;
      pix_cnt_q   <= pix_cnt_d;
      cdf_q       <= cdf_d;
      cdf_min_q   <= cdf_min_d;
      min_vld_q   <= min_vld_d;
      single_q    <= single_d;
      hist_vld_q  <= hist_vld_d;
      hist_addr_q <= hist_addr_d;
      hist_rd_q   <= hist_rd_d;
      pix_out_q   <= pix_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bin_we) bin_ram[bin_wa] <= bin_wd;
    if (lut_we) lut_ram[lut_wa] <= lut_wd;
  end

  he_div #(
    .NUM_W(NumW),
    .DEN_W(CNT_W)
  ) u_div (
    .clk_i  (clk),
    .rst_ni (reset),
    .start_i(div_start),
    .num_i  (num_val),
    .den_i  (den_val),
    .busy_o (div_busy),
    .done_o (div_done),
    .quot_o (div_quot),
    .rem_o  (div_rem)
  );

  logic unused_div;
  assign unused_div = ^{div_busy, div_rem, div_quot[NumW-1:PIX_W]};

  assign pix_out   = pix_out_q;
  assign out_valid = out_valid_q;
  assign done      = (state_q == StMap);
  assign busy      = (state_q == StClear) || (state_q == StHist) || (state_q == StCdf);

endmodule

// File: tb/tb_he_engine.sv
// Bench for he_engine at PIX_W=3, NUM_PIXELS=16: table-driven remap vectors
// through a scoreboard, plus hand-written reset, stall and restart sequences.
module tb_he_engine;

  logic       clk = 1'b0;
  logic       reset, start, pix_valid, pix_ready, out_valid, out_ready, done, busy;
  logic [2:0] pix_in, pix_out;

  he_engine #(
    .PIX_W     (3),
    .NUM_PIXELS(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pix_in   (pix_in),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_out  (pix_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       frame;
    logic [2:0] pin;
    logic [2:0] exp;
  } vec_t;

  vec_t       vecs [16];
  logic [2:0] sb [$];
  logic [2:0] cur_exp;
  logic [2:0] hold_val;
  logic       hold_vld = 1'b0;
  logic       tog_en   = 1'b0;
  int         n_pass   = 0;
  int         n_total  = 0;
  int         n_out    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [2:0] frame_pix(input int f, input int i);
    case (f)
      0:       return (i < 8) ? 3'd0 : 3'd7;
      1:       return 3'(i % 8);
      default: return 3'd2;
    endcase
  endfunction

  // Scoreboard: push on MAP accept, pop on delivered output.
  always @(negedge clk) begin
    if (hold_vld) chk("stall_stable", {28'd0, out_valid, pix_out}, {28'd0, 1'b1, hold_val});
    hold_vld = tog_en && out_valid && !out_ready;
    hold_val = pix_out;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got pixel %0d with empty scoreboard", pix_out);
      end else begin
        chk("map_out", {29'd0, pix_out}, {29'd0, sb.pop_front()});
        n_out++;
      end
    end
    if (done && pix_valid && pix_ready) sb.push_back(cur_exp);
  end

  always begin
    @(posedge clk);
    #2;
    if (tog_en) out_ready = ~out_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_px(input logic [2:0] pin, input logic [2:0] exp);
    logic acc;
    acc       = 1'b0;
    pix_in    = pin;
    cur_exp   = exp;
    pix_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pix_ready) begin
        acc = 1'b1;
        break;
      end
    end
    tick();
    pix_valid = 1'b0;
    if (!acc) chk("pix_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_frame(input int f, output int cycles);
    pulse_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 16; i++) drive_px(frame_pix(f, i), 3'd0);
    cycles = 0;
    while (!done && cycles < 2000) begin
      @(negedge clk);
      cycles++;
    end
    chk("done_reached", {31'd0, done}, 32'd1);
    chk("busy_low_in_map", {31'd0, busy}, 32'd0);
    tick();
  endtask

  task automatic apply_vectors(input int f);
    for (int v = 0; v < 16; v++) if (vecs[v].frame == f) drive_px(vecs[v].pin, vecs[v].exp);
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    repeat (3) tick();
    chk(name, sb.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cyc, t0, n0, n;
    vecs[0]  = '{0, 3'd7, 3'd7};
    vecs[1]  = '{0, 3'd3, 3'd0};
    vecs[2]  = '{0, 3'd0, 3'd0};
    vecs[3]  = '{0, 3'd6, 3'd0};
    for (int v = 0; v < 8; v++) vecs[4 + v] = '{1, 3'(v), 3'(v)};
    vecs[12] = '{2, 3'd5, 3'd5};
    vecs[13] = '{2, 3'd2, 3'd2};
    vecs[14] = '{2, 3'd0, 3'd0};
    vecs[15] = '{2, 3'd7, 3'd7};

    reset = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_in = '0; out_ready = 1'b1; cur_exp = '0;
    repeat (3) tick();
    chk("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pix_out", {29'd0, pix_out}, 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    // Frame 0: 8x0 + 8x7, D=8.
    run_frame(0, cyc);
    chk("cdf_uses_divider", {31'd0, cyc >= 64}, 32'd1);
    apply_vectors(0);
    drain("sb_empty_f0");

    // Frame 1: 2x each value, identity at full throughput, then stalled stream.
    run_frame(1, cyc);
    t0 = $time;
    apply_vectors(1);
    chk("throughput_cycles", ($time - t0) / 10, 32'd8);
    drain("sb_empty_f1");
    n0 = n_out;
    out_ready = 1'b1;
    tog_en    = 1'b1;
    for (int v = 0; v < 8; v++) drive_px(3'(v), 3'(v));
    tog_en = 1'b0;
    drain("sb_empty_stall");
    chk("stall_delivered", n_out - n0, 32'd8);

    // Frame 2: single-valued, D==0 identity without divides.
    run_frame(2, cyc);
    chk("d0_fast_cdf", {31'd0, cyc <= 12}, 32'd1);
    apply_vectors(2);
    drain("sb_empty_f2");

    // Reset in the middle of CDF.
    pulse_start();
    for (int i = 0; i < 16; i++) drive_px(frame_pix(0, i), 3'd0);
    repeat (5) tick();
    chk("in_cdf_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_pix_ready", {31'd0, pix_ready}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_pix_out", {29'd0, pix_out}, 32'd0);
    tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("idle_after_rst", {30'd0, busy, done}, 32'd0);
    run_frame(0, cyc);
    apply_vectors(0);
    drain("sb_empty_rerun");

    // start in MAP with a pending output: output discarded, CLEAR lasts L cycles.
    out_ready = 1'b0;
    drive_px(3'd7, 3'd7);
    chk("pending_valid", {31'd0, out_valid}, 32'd1);
    if (sb.size() > 0) void'(sb.pop_front());
    pulse_start();
    chk("restart_out_valid", {31'd0, out_valid}, 32'd0);
    chk("restart_done", {31'd0, done}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (!pix_ready && n < 20) begin
      tick();
      n++;
    end
    chk("clear_len", n, 32'd8);
    out_ready = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
